// File: rtl/uart_cmd_decoder.sv
// UART command-frame decoder: turns validated RX bytes into register-file
// writes/reads and ALU operations, and pushes read data / ALU results
// (low byte first) into the TX FIFO. All outputs are registered.
module uart_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_DATA_WIDTH = 16,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
  input  logic                      RF_RD_DATA_VLD,
  input  logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]     RF_ADDR,
  output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
  output logic                      RF_WR_EN,
  output logic                      RF_RD_EN,
  output logic [ALU_FUNC_WIDTH-1:0] ALU_FUN,
  output logic                      ALU_EN,
  output logic                      CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
  output logic                      FIFO_WR_INC,
  output logic                      CMD_ERR,
  output logic                      OVERRUN
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    ALU_A, ALU_B, ALU_FN, ALU_WAIT, PUSH_LO, PUSH_HI
  } state_t;

  state_t                      state_q, state_d;
  logic                        single_q, single_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [ALU_DATA_WIDTH-1:0]   res_q, res_d;

  logic [ADDR_WIDTH-1:0]       rf_addr_d;
  logic [DATA_WIDTH-1:0]       rf_wr_data_d;
  logic                        rf_wr_en_d, rf_rd_en_d;
  logic [ALU_FUNC_WIDTH-1:0]   alu_fun_d;
  logic                        alu_en_d, clk_gate_en_d;
  logic [DATA_WIDTH-1:0]       fifo_wr_data_d;
  logic                        fifo_wr_inc_d, cmd_err_d, overrun_d;

  // Next-state and next-output decode
  always_comb begin
    state_d        = state_q;
    single_d       = single_q;
    addr_d         = addr_q;
    res_d          = res_q;
    rf_addr_d      = RF_ADDR;
    rf_wr_data_d   = RF_WR_DATA;
    alu_fun_d      = ALU_FUN;
    fifo_wr_data_d = FIFO_WR_DATA;
    rf_wr_en_d     = 1'b0;
    rf_rd_en_d     = 1'b0;
    alu_en_d       = 1'b0;
    fifo_wr_inc_d  = 1'b0;
    cmd_err_d      = 1'b0;
    overrun_d      = 1'b0;

    case (state_q)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:     state_d = WR_ADDR;
          CMD_RD:     state_d = RD_ADDR;
          CMD_ALU_OP: state_d = ALU_A;
          CMD_ALU_NO: state_d = ALU_FN;
          default:    cmd_err_d = 1'b1;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_addr_d    = addr_q;
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        overrun_d = RX_D_VLD;
        if (RF_RD_DATA_VLD) begin
          res_d    = ALU_DATA_WIDTH'(RF_RD_DATA);
          single_d = 1'b1;
          state_d  = PUSH_LO;
        end
      end
      ALU_A: if (RX_D_VLD) begin
        rf_addr_d    = '0;
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        rf_addr_d    = ADDR_WIDTH'(1);
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_FN;
      end
      ALU_FN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: begin
        overrun_d = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          res_d    = ALU_OUT;
          single_d = 1'b0;
          state_d  = PUSH_LO;
        end
      end
      // A dropped byte defers the push by one cycle so OVERRUN and
      // FIFO_WR_INC never share a cycle.
      PUSH_LO: begin
        if (RX_D_VLD) begin
          overrun_d = 1'b1;
        end else if (!FIFO_FULL) begin
          fifo_wr_data_d = res_q[DATA_WIDTH-1:0];
          fifo_wr_inc_d  = 1'b1;
          state_d        = single_q ? IDLE : PUSH_HI;
        end
      end
      PUSH_HI: begin
        if (RX_D_VLD) begin
          overrun_d = 1'b1;
        end else if (!FIFO_FULL) begin
          fifo_wr_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          fifo_wr_inc_d  = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Gate stays open while the ALU is being programmed or computing.
    clk_gate_en_d = (state_d == ALU_FN) || (state_d == ALU_WAIT);
  end

  // Control state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      single_q     <= 1'b0;
      RF_ADDR      <= '0;
      RF_WR_DATA   <= '0;
      RF_WR_EN     <= 1'b0;
      RF_RD_EN     <= 1'b0;
      ALU_FUN      <= '0;
      ALU_EN       <= 1'b0;
      CLK_GATE_EN  <= 1'b0;
      FIFO_WR_DATA <= '0;
      FIFO_WR_INC  <= 1'b0;
      CMD_ERR      <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      state_q      <= state_d;
      single_q     <= single_d;
      RF_ADDR      <= rf_addr_d;
      RF_WR_DATA   <= rf_wr_data_d;
      RF_WR_EN     <= rf_wr_en_d;
      RF_RD_EN     <= rf_rd_en_d;
      ALU_FUN      <= alu_fun_d;
      ALU_EN       <= alu_en_d;
      CLK_GATE_EN  <= clk_gate_en_d;
      FIFO_WR_DATA <= fifo_wr_data_d;
      FIFO_WR_INC  <= fifo_wr_inc_d;
      CMD_ERR      <= cmd_err_d;
      OVERRUN      <= overrun_d;
    end
  end

  // Internal data latches (only consumed after the FSM has loaded them)
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    res_q  <= res_d;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command frames, expected strobes
// queued by the stimulus and consumed by a monitor on the falling edge.
module tb_uart_cmd_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_GATE_EN;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic        CMD_ERR;
  logic        OVERRUN;

  uart_cmd_decoder dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN),
    .RF_RD_EN(RF_RD_EN), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_INC(FIFO_WR_INC), .CMD_ERR(CMD_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_wr[$];    // {addr, data}
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_fifo[$];
  int          exp_cmd_err = 0;
  int          exp_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected strobe, value=%0h required=none", name, act);
  endtask

  function automatic logic [31:0] out_vec();
    return {1'b0, RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUN, ALU_EN,
            CLK_GATE_EN, FIFO_WR_DATA, FIFO_WR_INC, CMD_ERR, OVERRUN};
  endfunction

  task automatic monitor_loop();
    int n;
    logic [11:0] w;
    forever begin
      @(negedge CLK);
      n = int'(RF_WR_EN) + int'(RF_RD_EN) + int'(ALU_EN) + int'(FIFO_WR_INC)
        + int'(CMD_ERR) + int'(OVERRUN);
      if (n != 0) check("strobe_exclusive", n, 1);
      if (RF_WR_EN) begin
        if (exp_wr.size() == 0) unexpected("rf_wr", {RF_ADDR, RF_WR_DATA});
        else begin
          w = exp_wr.pop_front();
          check("rf_wr", {RF_ADDR, RF_WR_DATA}, w);
        end
      end
      if (RF_RD_EN) begin
        if (exp_rd.size() == 0) unexpected("rf_rd", RF_ADDR);
        else check("rf_rd_addr", RF_ADDR, exp_rd.pop_front());
      end
      if (ALU_EN) begin
        if (exp_alu.size() == 0) unexpected("alu_en", ALU_FUN);
        else begin
          check("alu_fun", ALU_FUN, exp_alu.pop_front());
          check("alu_gate_on", CLK_GATE_EN, 1);
        end
      end
      if (FIFO_WR_INC) begin
        if (exp_fifo.size() == 0) unexpected("fifo_push", FIFO_WR_DATA);
        else check("fifo_data", FIFO_WR_DATA, exp_fifo.pop_front());
      end
      if (CMD_ERR) begin
        if (exp_cmd_err == 0) unexpected("cmd_err", 1);
        else begin checks++; exp_cmd_err--; end
      end
      if (OVERRUN) begin
        if (exp_ovr == 0) unexpected("overrun", 1);
        else begin checks++; exp_ovr--; end
      end
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic alu_result(input logic [15:0] r);
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_OUT_VLD = 1'b0;
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", out_vec(), 32'h0);
    RST = 1'b0;
    idle(2);

    // Reset in the middle of a write: no write may appear
    send_byte(8'hAA);
    send_byte(8'h05);
    RST = 1'b1;
    #1;
    check("midreset_outputs", out_vec(), 32'h0);
    idle(2);
    RST = 1'b0;
    idle(2);
    exp_wr.push_back({4'h2, 8'h7E});
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h7E);
    check("write_strobe_now", RF_WR_EN, 1);
    idle(1);
    check("write_strobe_one_cycle", RF_WR_EN, 0);

    // Read with FIFO back-pressure
    FIFO_FULL = 1'b1;
    exp_rd.push_back(4'h2);
    exp_fifo.push_back(8'h7E);
    send_byte(8'hBB);
    send_byte(8'h02);
    idle(1);
    RF_RD_DATA     = 8'h7E;
    RF_RD_DATA_VLD = 1'b1;
    idle(1);
    RF_RD_DATA_VLD = 1'b0;
    idle(5);
    check("no_push_while_full", FIFO_WR_INC, 0);
    FIFO_FULL = 1'b0;
    idle(1);
    check("push_after_full_drops", {FIFO_WR_INC, FIFO_WR_DATA}, {1'b1, 8'h7E});
    idle(1);
    check("read_single_push", FIFO_WR_INC, 0);
    idle(2);

    // ALU with operands
    exp_wr.push_back({4'h0, 8'h02});
    exp_wr.push_back({4'h1, 8'h03});
    exp_alu.push_back(4'h0);
    exp_fifo.push_back(8'h05);
    exp_fifo.push_back(8'h00);
    send_byte(8'hCC);
    send_byte(8'h02);
    send_byte(8'h03);
    check("gate_on_in_alu_fn", CLK_GATE_EN, 1);
    send_byte(8'h00);
    idle(2);
    check("gate_on_in_alu_wait", CLK_GATE_EN, 1);
    alu_result(16'h0005);
    idle(3);
    check("gate_off_after_alu", CLK_GATE_EN, 0);

    // ALU without operands
    exp_alu.push_back(4'h2);
    exp_fifo.push_back(8'h34);
    exp_fifo.push_back(8'h12);
    send_byte(8'hDD);
    check("gate_on_after_dd", CLK_GATE_EN, 1);
    send_byte(8'h02);
    idle(1);
    alu_result(16'h1234);
    idle(3);

    // Unknown command stays in IDLE; next write has a truncated address
    exp_cmd_err++;
    send_byte(8'h55);
    check("cmd_err_pulse", CMD_ERR, 1);
    idle(1);
    check("cmd_err_one_cycle", CMD_ERR, 0);
    exp_wr.push_back({4'h3, 8'h5A});
    send_byte(8'hAA);
    send_byte(8'h13);
    send_byte(8'h5A);
    idle(2);

    // Overrun during ALU_WAIT; result still delivered
    exp_alu.push_back(4'h1);
    exp_ovr++;
    exp_fifo.push_back(8'hEF);
    exp_fifo.push_back(8'hBE);
    send_byte(8'hDD);
    send_byte(8'h01);
    idle(1);
    send_byte(8'h99);
    check("overrun_pulse", OVERRUN, 1);
    idle(1);
    alu_result(16'hBEEF);
    idle(4);

    // Everything expected must have been consumed
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("alu_queue_drained", exp_alu.size(), 0);
    check("fifo_queue_drained", exp_fifo.size(), 0);
    check("cmd_err_drained", exp_cmd_err, 0);
    check("overrun_drained", exp_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
